id_hazard_ctrl: RTL

- Sequences the decode stage and its register-file/ALU-input datapath.
- Tracks in-flight destination registers in a short age pipeline.
- Stalls decode on load-use hazards and issues bubbles into ID/EX on stall or flush.
- Produces registered forwarding selects for the two ALU operand muxes, including implicit stack-pointer (SP) reads by CALL/RET/PUSH/POP.

---
 rtl/id_hazard_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard control.
// Tracks in-flight destination registers in a LOAD_LAT-deep age pipeline.
// Stalls decode on load-use hazards, bubbles ID/EX on stall or flush, and
// produces registered ALU-operand forwarding selects. Implicit SP reads by
// CALL/RET/PUSH/POP are treated as a source-1 read of SP_REG.
// Optional macro ID_HAZARD_STATS_EN adds a saturating stall-cycle counter.
module id_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 2,   // 2..4
  parameter int unsigned SP_REG   = 29
) (
  input  logic       clk,
  input  logic       rst,            // asynchronous, active low
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic       id_rs_used,
  input  logic [4:0] id_rt,
  input  logic       id_rt_used,
  input  logic [4:0] id_rd,
  input  logic       id_writes_rd,
  input  logic       id_is_load,
  input  logic       id_sp_op,
  input  logic       id_pop,
  input  logic       ex_flush,
  output logic       stall,
  output logic       issue,
  output logic       bubble,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2
`ifdef ID_HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [4:0] SP = 5'(SP_REG);

  typedef struct packed {
    logic       vld;
    logic [4:0] rnum;
    logic       ld;
  } ent_t;

  // e_q[k] is the instruction k+1 stages past ID
  ent_t [LOAD_LAT-1:0] e_q;
  ent_t                e0_d;

  logic [4:0]          src1, src2;
  logic                src1_v, src2_v;
  logic [LOAD_LAT-1:0] hit1, hit2;
  logic                lu_hit;
  logic                dst_sp;
  logic [1:0]          fwd1_d, fwd2_d, fwd1_q, fwd2_q;
  logic                bubble_q;

  // Stack ops read SP through the source-1 port
  assign src1   = id_sp_op ? SP : id_rs;
  assign src1_v = id_sp_op | id_rs_used;
  assign src2   = id_rt;
  assign src2_v = id_rt_used;

  // Per-entry source match; r0 is hardwired zero and never matches
  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_hit
    assign hit1[k] = src1_v & (|src1) & e_q[k].vld & (e_q[k].rnum == src1);
    assign hit2[k] = src2_v & (|src2) & e_q[k].vld & (e_q[k].rnum == src2);
  end

  // Load-use: a load whose data is not yet forwardable (age < LOAD_LAT-1)
  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < LOAD_LAT - 1; k++)
      lu_hit = lu_hit | (e_q[k].ld & (hit1[k] | hit2[k]));
  end

  // Flush dominates stall
  assign stall = id_valid & ~ex_flush & lu_hit;
  assign issue = id_valid & ~ex_flush & ~lu_hit;

  // New tracker entry; POP's SP update is ALU-forwardable so only rd is tracked
  always_comb begin
    dst_sp    = id_sp_op & ~id_pop;
    e0_d.vld  = issue & (dst_sp | id_writes_rd | id_pop);
    e0_d.rnum = dst_sp ? SP : id_rd;
    e0_d.ld   = id_is_load | id_pop;
  end

  // Youngest match wins: EX/MEM (non-load) first, then MEM/WB
  always_comb begin
    fwd1_d = 2'b00;
    fwd2_d = 2'b00;
    if (hit1[0] & ~e_q[0].ld) fwd1_d = 2'b01;
    else if (hit1[1])         fwd1_d = 2'b10;
    if (hit2[0] & ~e_q[0].ld) fwd2_d = 2'b01;
    else if (hit2[1])         fwd2_d = 2'b10;
  end

  // Age pipeline shifts every cycle; older instructions complete even on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q <= '0;
    end else begin
      for (int k = 1; k < LOAD_LAT; k++) e_q[k] <= e_q[k-1];
      e_q[0] <= e0_d;
    end
  end

  // ID/EX bubble and forwarding selects, zeroed when nothing issues
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= 1'b1;
      fwd1_q   <= 2'b00;
      fwd2_q   <= 2'b00;
    end else begin
      bubble_q <= ~issue;
      fwd1_q   <= issue ? fwd1_d : 2'b00;
      fwd2_q   <= issue ? fwd2_d : 2'b00;
    end
  end

  assign bubble   = bubble_q;
  assign fwd_sel1 = fwd1_q;
  assign fwd_sel2 = fwd2_q;

`ifdef ID_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
